// File: rtl/pipe_front_regs_if.sv
// Fetch/decode/execute front-end pipeline register bundle: hazard controls in,
// register contents and performance counters out.
interface pipe_front_regs_if #(parameter int CTRL_W = 10);
  logic              stallF, stallD, flushD, flushE, PC_srcE;
  logic [31:0]       PC_targetE, instrF;
  logic [CTRL_W-1:0] ctrlD;
  logic [4:0]        rs1D, rs2D, rdD;
  logic [31:0]       PCF, instrD, PCD, PCPlus4D;
  logic              validD;
  logic [CTRL_W-1:0] ctrlE;
  logic [4:0]        rs1E, rs2E, rdE;
  logic [31:0]       PCE, PCPlus4E;
  logic              validE;
  logic [15:0]       stall_cnt, flush_cnt;

  modport slave (
    input  stallF, stallD, flushD, flushE, PC_srcE, PC_targetE, instrF,
           ctrlD, rs1D, rs2D, rdD,
    output PCF, instrD, PCD, PCPlus4D, validD, ctrlE, rs1E, rs2E, rdE,
           PCE, PCPlus4E, validE, stall_cnt, flush_cnt
  );
  modport master (
    output stallF, stallD, flushD, flushE, PC_srcE, PC_targetE, instrF,
           ctrlD, rs1D, rs2D, rdD,
    input  PCF, instrD, PCD, PCPlus4D, validD, ctrlE, rs1E, rs2E, rdE,
           PCE, PCPlus4E, validE, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers with stall/flush/redirect control.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush counters.
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CTRL_W    = 10
) (
  input logic clk,
  input logic rst_n,
  pipe_front_regs_if.slave bus
);
  logic [31:0]       r_pcf, r_instrd, r_pcd, r_pcp4d, r_pce, r_pcp4e;
  logic              r_validd, r_valide;
  logic [CTRL_W-1:0] r_ctrle;
  logic [4:0]        r_rs1e, r_rs2e, r_rde;
  logic [31:0]       w_pcf_plus4;

  assign w_pcf_plus4 = r_pcf + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf    <= RESET_PC;
      r_instrd <= NOP_INSTR;
      r_pcd    <= '0;
      r_pcp4d  <= '0;
      r_validd <= 1'b0;
      r_ctrle  <= '0;
      r_rs1e   <= '0;
      r_rs2e   <= '0;
      r_rde    <= '0;
      r_pce    <= '0;
      r_pcp4e  <= '0;
      r_valide <= 1'b0;
    end else begin
      if (bus.PC_srcE)     r_pcf <= bus.PC_targetE;
      else if (!bus.stallF) r_pcf <= w_pcf_plus4;

      if (bus.flushD) begin
        r_instrd <= NOP_INSTR;
        r_pcd    <= '0;
        r_pcp4d  <= '0;
        r_validd <= 1'b0;
      end else if (!bus.stallD) begin
        r_instrd <= bus.instrF;
        r_pcd    <= r_pcf;
        r_pcp4d  <= w_pcf_plus4;
        r_validd <= 1'b1;
      end

      if (bus.flushE) begin
        r_ctrle  <= '0;
        r_rs1e   <= '0;
        r_rs2e   <= '0;
        r_rde    <= '0;
        r_pce    <= '0;
        r_pcp4e  <= '0;
        r_valide <= 1'b0;
      end else begin
        // Gate control with validity so an empty decode slot never carries
        // reg_wr/result_src into execute.
        r_ctrle  <= r_validd ? bus.ctrlD : '0;
        r_rs1e   <= bus.rs1D;
        r_rs2e   <= bus.rs2D;
        r_rde    <= bus.rdD;
        r_pce    <= r_pcd;
        r_pcp4e  <= r_pcp4d;
        r_valide <= r_validd;
      end
    end
  end

  assign bus.PCF      = r_pcf;
  assign bus.instrD   = r_instrd;
  assign bus.PCD      = r_pcd;
  assign bus.PCPlus4D = r_pcp4d;
  assign bus.validD   = r_validd;
  assign bus.ctrlE    = r_ctrle;
  assign bus.rs1E     = r_rs1e;
  assign bus.rs2E     = r_rs2e;
  assign bus.rdE      = r_rde;
  assign bus.PCE      = r_pce;
  assign bus.PCPlus4E = r_pcp4e;
  assign bus.validE   = r_valide;

`ifdef PIPE_PERF_CNT_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.stallD && !bus.flushD && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (bus.PC_srcE && r_flush_cnt != 16'hFFFF)
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench: directed vector table, corner sequences and random
// hazard stimulus compared against a rule-level reference model.
module tb_pipe_front_regs;
  localparam int          CW  = 10;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_front_regs_if #(.CTRL_W(CW)) bus ();
  pipe_front_regs #(.RESET_PC(RPC), .NOP_INSTR(NOP), .CTRL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0] m_pc, m_iD, m_pD, m_p4D, m_pE, m_p4E;
  logic        m_vD, m_vE;
  logic [CW-1:0] m_cE;
  logic [4:0]  m_r1, m_r2, m_rd;
  logic [15:0] m_sc, m_fc;

  typedef struct {
    logic sF, sD, fD, fE, ps;
    logic [31:0] tgt, ins;
    logic [CW-1:0] ctl;
    logic [31:0] ePC, eInsD;
    logic eVD, eVE;
    logic [CW-1:0] eCtl;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    m_pc = RPC; m_iD = NOP; m_pD = 0; m_p4D = 0; m_vD = 0;
    m_cE = 0; m_r1 = 0; m_r2 = 0; m_rd = 0; m_pE = 0; m_p4E = 0; m_vE = 0;
    m_sc = 0; m_fc = 0;
  endfunction

  // Advance one cycle: each stage reads the older stage's pre-edge contents.
  function automatic void mdl_step();
    if (bus.flushE) begin
      m_cE = 0; m_r1 = 0; m_r2 = 0; m_rd = 0; m_pE = 0; m_p4E = 0; m_vE = 0;
    end else begin
      m_cE = m_vD ? bus.ctrlD : '0;
      m_r1 = bus.rs1D; m_r2 = bus.rs2D; m_rd = bus.rdD;
      m_pE = m_pD; m_p4E = m_p4D; m_vE = m_vD;
    end
    if (bus.flushD) begin
      m_iD = NOP; m_pD = 0; m_p4D = 0; m_vD = 0;
    end else if (!bus.stallD) begin
      m_iD = bus.instrF; m_pD = m_pc; m_p4D = m_pc + 32'd4; m_vD = 1;
    end
`ifdef PIPE_PERF_CNT_EN
    if (bus.stallD && !bus.flushD && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    if (bus.PC_srcE && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
`endif
    m_pc = bus.PC_srcE ? bus.PC_targetE : (bus.stallF ? m_pc : m_pc + 32'd4);
  endfunction

  task automatic check_all();
    chk("PCF", bus.PCF, m_pc);
    chk("instrD", bus.instrD, m_iD);
    chk("PCD", bus.PCD, m_pD);
    chk("PCPlus4D", bus.PCPlus4D, m_p4D);
    chk("validD", {31'd0, bus.validD}, {31'd0, m_vD});
    chk("ctrlE", {22'd0, bus.ctrlE}, {22'd0, m_cE});
    chk("rs1E", {27'd0, bus.rs1E}, {27'd0, m_r1});
    chk("rs2E", {27'd0, bus.rs2E}, {27'd0, m_r2});
    chk("rdE", {27'd0, bus.rdE}, {27'd0, m_rd});
    chk("PCE", bus.PCE, m_pE);
    chk("PCPlus4E", bus.PCPlus4E, m_p4E);
    chk("validE", {31'd0, bus.validE}, {31'd0, m_vE});
    chk("stall_cnt", {16'd0, bus.stall_cnt}, {16'd0, m_sc});
    chk("flush_cnt", {16'd0, bus.flush_cnt}, {16'd0, m_fc});
  endtask

  task automatic cyc(input logic sF, sD, fD, fE, ps, input logic [31:0] tgt, ins,
                     input logic [CW-1:0] ctl, input bit do_chk);
    bus.stallF = sF; bus.stallD = sD; bus.flushD = fD; bus.flushE = fE;
    bus.PC_srcE = ps; bus.PC_targetE = tgt; bus.instrF = ins; bus.ctrlD = ctl;
    bus.rs1D = 5'($urandom); bus.rs2D = 5'($urandom); bus.rdD = 5'($urandom);
    mdl_step();
    @(posedge clk);
    #1;
    if (do_chk) check_all();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_PCF"}, bus.PCF, RPC);
    chk({tag, "_instrD"}, bus.instrD, NOP);
    chk({tag, "_validD"}, {31'd0, bus.validD}, 32'd0);
    chk({tag, "_validE"}, {31'd0, bus.validE}, 32'd0);
    chk({tag, "_ctrlE"}, {22'd0, bus.ctrlE}, 32'd0);
    chk({tag, "_cnts"}, {bus.stall_cnt, bus.flush_cnt}, 32'd0);
  endtask

  initial begin
    logic [15:0] sat_exp;
    tbl[0] = '{0,0,0,0,0, 32'h0,   32'hA, 10'h000, 32'h4,   32'hA,  1,0, 10'h000};
    tbl[1] = '{0,0,0,0,0, 32'h0,   32'hB, 10'h001, 32'h8,   32'hB,  1,1, 10'h001};
    tbl[2] = '{1,1,0,1,0, 32'h0,   32'hC, 10'h003, 32'h8,   32'hB,  1,0, 10'h000};
    tbl[3] = '{0,0,0,0,0, 32'h0,   32'hC, 10'h003, 32'hC,   32'hC,  1,1, 10'h003};
    tbl[4] = '{0,0,1,1,1, 32'h100, 32'hD, 10'h000, 32'h100, NOP,    0,0, 10'h000};
    tbl[5] = '{0,0,0,0,0, 32'h0,   32'hE, 10'h3FF, 32'h104, 32'hE,  1,0, 10'h000};
    tbl[6] = '{1,1,1,0,1, 32'h40,  32'hF, 10'h155, 32'h40,  NOP,    0,1, 10'h155};

    rst_n = 1'b0;
    bus.stallF = 0; bus.stallD = 0; bus.flushD = 0; bus.flushE = 0; bus.PC_srcE = 0;
    bus.PC_targetE = 0; bus.instrF = 0; bus.ctrlD = 0;
    bus.rs1D = 0; bus.rs2D = 0; bus.rdD = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    mdl_reset();

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].sF, tbl[i].sD, tbl[i].fD, tbl[i].fE, tbl[i].ps,
          tbl[i].tgt, tbl[i].ins, tbl[i].ctl, 1'b1);
      chk($sformatf("v%0d_PCF", i), bus.PCF, tbl[i].ePC);
      chk($sformatf("v%0d_instrD", i), bus.instrD, tbl[i].eInsD);
      chk($sformatf("v%0d_validD", i), {31'd0, bus.validD}, {31'd0, tbl[i].eVD});
      chk($sformatf("v%0d_validE", i), {31'd0, bus.validE}, {31'd0, tbl[i].eVE});
      chk($sformatf("v%0d_ctrlE", i), {22'd0, bus.ctrlE}, {22'd0, tbl[i].eCtl});
    end

    // PC wrap at the top of the address space
    cyc(0,0,1,1,1, 32'hFFFF_FFFC, 32'h77, 10'h0, 1'b1);
    cyc(0,0,0,0,0, 32'h0, 32'h78, 10'h2, 1'b1);
    chk("wrap_PCF", bus.PCF, 32'h0);
    chk("wrap_PCD", bus.PCD, 32'hFFFF_FFFC);
    chk("wrap_PCPlus4D", bus.PCPlus4D, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] t;
      r = $urandom_range(0, 9);
      t = $urandom & 32'hFFFF_FFFC;
      case (r)
        0: cyc(1,1,0,1,0, t, $urandom, CW'($urandom), 1'b1);
        1: cyc(0,0,1,1,1, t, $urandom, CW'($urandom), 1'b1);
        2: cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               t, $urandom, CW'($urandom), 1'b1);
        default: cyc(0,0,0,0,0, t, $urandom, CW'($urandom), 1'b1);
      endcase
    end

    // asynchronous reset in the middle of a stall/redirect cycle
    bus.stallF = 1; bus.stallD = 1; bus.PC_srcE = 1; bus.PC_targetE = 32'h200;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    @(posedge clk);
    #1;
    chk_reset_vals("arst_hold");
    rst_n = 1'b1;
    mdl_reset();
    cyc(0,0,0,0,0, 32'h0, 32'h55, 10'h0, 1'b1);
    chk("post_rst_PCF", bus.PCF, RPC + 32'd4);

    // long stall to drive the stall counter into saturation
    for (int i = 0; i < 70000; i++) cyc(1,1,0,0,0, 32'h0, 32'h0, 10'h0, 1'b0);
    check_all();
`ifdef PIPE_PERF_CNT_EN
    sat_exp = 16'hFFFF;
`else
    sat_exp = 16'h0000;
`endif
    chk("sat_stall_cnt", {16'd0, bus.stall_cnt}, {16'd0, sat_exp});
    chk("sat_PCF", bus.PCF, RPC + 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
